// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the byte producers / TSR side and uart_tx_arbiter.
// The slave modport is the arbiter's view of the bundle; the master modport is the environment's view.
interface uart_tx_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 8
);
   localparam int unsigned GW = $clog2(NREQ);

   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic               tsr_busy;
   logic               tx_start;
   logic [DW-1:0]      tx_data;
   logic [NREQ-1:0]    ack;
   logic [GW-1:0]      grant_id;
   logic               active;
   logic               timeout_err;

   modport slave (
      input  req, req_data, tsr_busy,
      output tx_start, tx_data, ack, grant_id, active, timeout_err
   );

   modport master (
      output req, req_data, tsr_busy,
      input  tx_start, tx_data, ack, grant_id, active, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers;
// all outputs registered, frame completion tracked through tsr_busy with a start timeout.
module uart_tx_arbiter #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned DW           = 8,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic             BCLK,
   input  logic             RST_N,
   uart_tx_arbiter_if.slave arb
);
   localparam int unsigned   GW       = $clog2(NREQ);
   localparam int unsigned   TW       = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [GW-1:0] LAST_ID  = GW'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [GW-1:0]   r_ptr, w_ptr_nxt;
   logic [GW-1:0]   r_grant_id, w_grant_id_nxt;
   logic [TW-1:0]   r_timer, w_timer_nxt;
   logic            r_tx_start, w_tx_start_nxt;
   logic [DW-1:0]   r_tx_data, w_tx_data_nxt;
   logic [NREQ-1:0] r_ack, w_ack_nxt;
   logic            r_active, w_active_nxt;
   logic            r_timeout_err, w_timeout_err_nxt;

   logic [NREQ-1:0] w_elig;
   logic [NREQ-1:0] w_rot;
   logic            w_found;
   int unsigned     w_idx;
   logic [GW-1:0]   w_win;
   logic [DW-1:0]   w_win_data;
   logic [GW-1:0]   w_ptr_after;

   // Rotate eligibility so bit 0 is the requester at ptr, then take the lowest set bit.
   always_comb begin
      w_elig  = arb.req & ~r_ack;
      w_rot   = NREQ'({w_elig, w_elig} >> r_ptr);
      w_found = 1'b0;
      w_idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_idx   = 32'(r_ptr) + k;
         end
      end
      if (w_idx >= NREQ) begin
         w_idx = w_idx - NREQ;
      end
      w_win       = GW'(w_idx);
      w_win_data  = DW'(arb.req_data >> (32'(w_win) * DW));
      w_ptr_after = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_ptr_nxt         = r_ptr;
      w_grant_id_nxt    = r_grant_id;
      w_timer_nxt       = r_timer;
      w_tx_start_nxt    = 1'b0;
      w_tx_data_nxt     = r_tx_data;
      w_ack_nxt         = '0;
      w_timeout_err_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (!arb.tsr_busy && w_found) begin
               w_tx_data_nxt  = w_win_data;
               w_grant_id_nxt = w_win;
               w_state_nxt    = START;
            end
         end
         START: begin
            w_tx_start_nxt = 1'b1;
            w_timer_nxt    = '0;
            w_state_nxt    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (arb.tsr_busy) begin
               w_state_nxt = WAIT_DONE;
            end else if (r_timer == TMO_LAST) begin
               w_timeout_err_nxt = 1'b1;
               w_ptr_nxt         = w_ptr_after;
               w_state_nxt       = IDLE;
            end else if (r_timer != '1) begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!arb.tsr_busy) begin
               w_ack_nxt   = NREQ'(1) << r_grant_id;
               w_ptr_nxt   = w_ptr_after;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_active_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge BCLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state       <= IDLE;
         r_ptr         <= '0;
         r_grant_id    <= '0;
         r_timer       <= '0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_ack         <= '0;
         r_active      <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_timer       <= w_timer_nxt;
         r_tx_start    <= w_tx_start_nxt;
         r_tx_data     <= w_tx_data_nxt;
         r_ack         <= w_ack_nxt;
         r_active      <= w_active_nxt;
         r_timeout_err <= w_timeout_err_nxt;
      end
   end

   assign arb.tx_start    = r_tx_start;
   assign arb.tx_data     = r_tx_data;
   assign arb.ack         = r_ack;
   assign arb.grant_id    = r_grant_id;
   assign arb.active      = r_active;
   assign arb.timeout_err = r_timeout_err;
endmodule
